// File: rtl/mips_prog_encoder.sv
// Sequential MIPS instruction encoder and program loader: accepts symbolic
// descriptors over valid/ready and writes encoded words into instruction memory.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; base address latched on start
// RUN   | in_ready high; a descriptor is encoded and captured on handshake
// WR    | one-cycle im_we with the captured address/word
// DONE  | one-cycle done pulse, then back to IDLE
module mips_prog_encoder #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0] K_SLL  = 5'd8;
  localparam logic [4:0] K_SRL  = 5'd10;
  localparam logic [4:0] K_JR   = 5'd13;
  localparam logic [4:0] K_JALR = 5'd14;
  localparam logic [4:0] K_LUI  = 5'd20;
  localparam logic [4:0] K_J    = 5'd24;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_cnt_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;
  logic              last_q;
  logic              err_q;
  logic              ovf_q;
  logic [ADDR_W:0]   word_cnt_q;

  // Encoder: kind decode and field forcing
  logic        is_rtype;
  logic        is_jtype;
  logic        kind_legal;
  logic [5:0]  funct;
  logic [5:0]  opcode;
  logic [4:0]  rs_f;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  sh_f;
  logic [31:0] enc_word;

  always_comb begin
    is_rtype   = 1'b0;
    is_jtype   = 1'b0;
    kind_legal = 1'b1;
    funct      = 6'h00;
    opcode     = 6'h00;
    case (in_kind)
      5'd0:  begin is_rtype = 1'b1; funct = 6'h20; end
      5'd1:  begin is_rtype = 1'b1; funct = 6'h22; end
      5'd2:  begin is_rtype = 1'b1; funct = 6'h24; end
      5'd3:  begin is_rtype = 1'b1; funct = 6'h25; end
      5'd4:  begin is_rtype = 1'b1; funct = 6'h2A; end
      5'd5:  begin is_rtype = 1'b1; funct = 6'h2B; end
      5'd6:  begin is_rtype = 1'b1; funct = 6'h21; end
      5'd7:  begin is_rtype = 1'b1; funct = 6'h23; end
      5'd8:  begin is_rtype = 1'b1; funct = 6'h00; end
      5'd9:  begin is_rtype = 1'b1; funct = 6'h27; end
      5'd10: begin is_rtype = 1'b1; funct = 6'h02; end
      5'd11: begin is_rtype = 1'b1; funct = 6'h04; end
      5'd12: begin is_rtype = 1'b1; funct = 6'h06; end
      5'd13: begin is_rtype = 1'b1; funct = 6'h08; end
      5'd14: begin is_rtype = 1'b1; funct = 6'h09; end
      5'd15: opcode = 6'h08;
      5'd16: opcode = 6'h0D;
      5'd17: opcode = 6'h23;
      5'd18: opcode = 6'h2B;
      5'd19: opcode = 6'h04;
      5'd20: opcode = 6'h0F;
      5'd21: opcode = 6'h0A;
      5'd22: opcode = 6'h05;
      5'd23: opcode = 6'h0C;
      5'd24: begin is_jtype = 1'b1; opcode = 6'h02; end
      default: kind_legal = 1'b0;
    endcase
  end

  always_comb begin
    rs_f = in_rs;
    rt_f = in_rt;
    rd_f = in_rd;
    sh_f = in_shamt;
    if (is_rtype && in_kind != K_SLL && in_kind != K_SRL) sh_f = 5'd0;
    if (in_kind == K_SLL || in_kind == K_SRL || in_kind == K_LUI) rs_f = 5'd0;
    if (in_kind == K_JR) begin
      rt_f = 5'd0;
      rd_f = 5'd0;
    end
    if (in_kind == K_JALR) rt_f = 5'd0;
  end

  always_comb begin
    if (is_jtype)
      enc_word = {opcode, in_target};
    else if (is_rtype)
      enc_word = {6'b000000, rs_f, rt_f, rd_f, sh_f, funct};
    else
      enc_word = {opcode, rs_f, rt_f, in_imm};
  end

  wire accept   = (state_q == ST_RUN) && in_valid;
  wire wr_ovf   = (im_addr_q == ADDR_MAX);
  wire unused_k = (in_kind == K_J);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          if (kind_legal)   state_d = ST_WR;
          else if (in_last) state_d = ST_DONE;
        end
      end
      ST_WR: begin
        if (last_q || wr_ovf) state_d = ST_DONE;
        else                  state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_cnt_q <= '0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_cnt_q <= base_addr;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            word_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (kind_legal) begin
              im_addr_q  <= addr_cnt_q;
              im_wdata_q <= enc_word;
              last_q     <= in_last;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_WR: begin
          addr_cnt_q <= addr_cnt_q + ADDR_ONE;
          word_cnt_q <= word_cnt_q + CNT_ONE;
          // overflow only counts when the session still wanted more words
          if (!last_q && wr_ovf) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state_q == ST_RUN);
  assign im_we    = (state_q == ST_WR);
  assign done     = (state_q == ST_DONE);
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign err      = err_q;
  assign ovf      = ovf_q;
  assign word_cnt = word_cnt_q;

endmodule
